// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit frame stage.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                         input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_tick.sv
// Bit-time counter: counts 0..OVERSAMPLE-1 and flags the last count of each bit.
module uart_bit_tick #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic bit_end_o
);

    localparam logic [7:0] LAST_CNT = 8'(OVERSAMPLE - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       bit_end_q, bit_end_d;

    // Next count: restart forces phase zero so every frame starts on a fresh bit
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = 8'd0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        bit_end_d = (cnt_d == LAST_CNT);
    end

    // Counter and registered end-of-bit flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 8'd0;
            bit_end_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_end_q <= bit_end_d;
        end
    end

    assign bit_end_o = bit_end_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer with a one-entry holding buffer.
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wrsig,
    input  logic [UART_DATA_BITS-1:0] datain,
    output logic                      tx,
    output logic                      idle,
    output logic                      overflow
);

    if ((OVERSAMPLE < 2) || (OVERSAMPLE > 255) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
        (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_cfg
        $error("uart_tx_frame: unsupported parameter combination");
    end

    uart_state_e               state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] buf_q, buf_d;
    logic                      buf_full_q, buf_full_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [1:0]                stop_cnt_q, stop_cnt_d;
    logic                      wrsig_q;
    logic                      tx_q, tx_d;
    logic                      idle_q, idle_d;
    logic                      ovf_q, ovf_d;
`ifdef UART_PARITY_EN
    logic                      par_q, par_d;
`endif

    logic                      bit_end_s;
    logic                      wr_edge_s;
    logic                      data_last_s;
    logic                      stop_last_s;
    logic                      frame_end_s;
    logic                      drain_s;
    logic                      direct_load_s;
    logic                      buf_write_s;
    logic                      start_frame_s;
    logic [UART_DATA_BITS-1:0] load_byte_s;

    uart_bit_tick #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i(start_frame_s),
        .bit_end_o(bit_end_s)
    );

    // A frame-end write with an empty buffer is treated like an idle write so no gap appears
    assign wr_edge_s     = wrsig & ~wrsig_q;
    assign data_last_s   = bit_end_s && (bit_idx_q == 3'd7);
    assign stop_last_s   = (stop_cnt_q == 2'(STOP_BITS - 1));
    assign frame_end_s   = (state_q == ST_STOP) && bit_end_s && stop_last_s;
    assign drain_s       = frame_end_s && buf_full_q;
    assign direct_load_s = wr_edge_s && ((state_q == ST_IDLE) || (frame_end_s && !buf_full_q));
    assign buf_write_s   = wr_edge_s && !direct_load_s && (!buf_full_q || drain_s);
    assign start_frame_s = direct_load_s || drain_s;
    assign load_byte_s   = drain_s ? buf_q : datain;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_frame_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (data_last_s) begin
`ifdef UART_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
`ifdef UART_PARITY_EN
                if (bit_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_STOP: begin
                if (frame_end_s) begin
                    state_d = start_frame_s ? ST_START : ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: shift register, counters, holding buffer
    always_comb begin
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
`ifdef UART_PARITY_EN
        par_d      = par_q;
`endif
        if (start_frame_s) begin
            shift_d   = load_byte_s;
            bit_idx_d = 3'd0;
`ifdef UART_PARITY_EN
            par_d     = uart_parity(load_byte_s, PARITY_ODD != 0);
`endif
        end else if ((state_q == ST_DATA) && bit_end_s) begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
        end else begin
            shift_d   = shift_q;
        end

        if (state_q != ST_STOP) begin
            stop_cnt_d = 2'd0;
        end else if (bit_end_s) begin
            stop_cnt_d = stop_cnt_q + 2'd1;
        end else begin
            stop_cnt_d = stop_cnt_q;
        end

        if (buf_write_s) begin
            buf_d      = datain;
            buf_full_d = 1'b1;
        end else if (drain_s) begin
            buf_full_d = 1'b0;
        end else begin
            buf_full_d = buf_full_q;
        end
    end

    // FSM output logic, computed from next state so outputs can be registered
    always_comb begin
        tx_d = UART_IDLE_LEVEL;
        case (state_d)
            ST_IDLE:   tx_d = UART_IDLE_LEVEL;
            ST_START:  tx_d = UART_START_LEVEL;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_d = par_d;
`else
            ST_PARITY: tx_d = UART_IDLE_LEVEL;
`endif
            ST_STOP:   tx_d = UART_IDLE_LEVEL;
            default:   tx_d = UART_IDLE_LEVEL;
        endcase
        idle_d = (state_d == ST_IDLE) && !buf_full_d;
        ovf_d  = wr_edge_s && !direct_load_s && !buf_write_s;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 2'd0;
            wrsig_q    <= 1'b0;
            tx_q       <= UART_IDLE_LEVEL;
            idle_q     <= 1'b1;
            ovf_q      <= 1'b0;
`ifdef UART_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            wrsig_q    <= wrsig;
            tx_q       <= tx_d;
            idle_q     <= idle_d;
            ovf_q      <= ovf_d;
`ifdef UART_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign idle     = idle_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: a timeline model predicts frames, overflow and idle.
module tb_uart_tx_frame;

    localparam int OS   = 16;
    localparam int SB   = 1;
    localparam int PODD = 0;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = 1 + 8 + PB + SB;
    localparam int FRAME = NBITS * OS;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       wrsig  = 1'b0;
    logic [7:0] datain = 8'h00;
    logic       tx;
    logic       idle;
    logic       overflow;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] b;
        int         start;
    } frame_t;

    frame_t exp_q[$];
    int     ovf_q[$];
    int     last_start  = 0;
    int     last_end    = 0;
    int     chain_start = 0;

    uart_tx_frame #(
        .OVERSAMPLE(OS),
        .STOP_BITS (SB),
        .PARITY_ODD(PODD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrsig   (wrsig),
        .datain  (datain),
        .tx      (tx),
        .idle    (idle),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Timeline model: a write at edge t is accepted unless a frame is still waiting to start.
    task automatic model_write(input int t, input logic [7:0] b);
        frame_t f;
        if (last_start > t) begin
            ovf_q.push_back(t);
        end else begin
            if (last_end <= t) begin
                f.start     = t;
                chain_start = t;
            end else begin
                f.start = last_end;
            end
            f.b = b;
            exp_q.push_back(f);
            last_start = f.start;
            last_end   = f.start + FRAME;
        end
    endtask

    task automatic write_at(input int t, input logic [7:0] b, input int hold);
        while (cyc < t - 1) @(negedge clk);
        model_write(cyc + 1, b);
        wrsig  = 1'b1;
        datain = b;
        repeat (hold) @(negedge clk);
        wrsig  = 1'b0;
        datain = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((cyc < last_end + OS) || (exp_q.size() != 0)) begin
            @(negedge clk);
            n++;
            if (n > 5000) begin
                check("drain_timeout", 1, 0);
                break;
            end
        end
    endtask

    // Monitor: decode frames on tx, check idle and overflow each cycle
    initial begin : monitor
        int               mstate;
        int               sst;
        int               rel;
        logic             prev;
        logic [NBITS-1:0] bits;
        frame_t           f;
        mstate = 0;
        sst    = 0;
        prev   = 1'b1;
        bits   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mstate = 0;
                prev   = 1'b1;
            end else begin
                check("idle", int'(idle), (cyc >= chain_start && cyc < last_end) ? 0 : 1);
                if (overflow) begin
                    if (ovf_q.size() == 0) check("overflow_unexpected", 1, 0);
                    else check("overflow_cycle", cyc, ovf_q.pop_front());
                end
                if (mstate == 0) begin
                    if (prev && !tx) begin
                        mstate = 1;
                        sst    = cyc;
                    end
                end else begin
                    rel = cyc - sst;
                    if ((rel % OS) == (OS / 2)) begin
                        bits[rel / OS] = tx;
                        if ((rel / OS) == NBITS - 1) begin
                            mstate = 0;
                            if (exp_q.size() == 0) begin
                                check("unexpected_frame", 1, 0);
                            end else begin
                                f = exp_q.pop_front();
                                check("frame_start", sst, f.start);
                                check("start_bit", int'(bits[0]), 0);
                                check("data", int'(bits[8:1]), int'(f.b));
`ifdef UART_PARITY_EN
                                check("parity", int'(bits[9]), ($countones(f.b) + PODD) % 2);
`endif
                                for (int k = 0; k < SB; k++)
                                    check("stop_bit", int'(bits[9 + PB + k]), 1);
                            end
                        end
                    end
                end
                prev = tx;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int b;
        #1 rst_n = 1'b0;
        #2;
        check("reset_tx", int'(tx), 1);
        check("reset_idle", int'(idle), 1);
        check("reset_overflow", int'(overflow), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        b = cyc + 2;
        write_at(b, 8'h55, 1);
        drain();

        b = cyc + 2;
        write_at(b, 8'hA3, 1);
        write_at(b + 20, 8'h0F, 1);
        drain();

        b = cyc + 2;
        write_at(b, 8'h01, 1);
        write_at(b + 20, 8'h02, 1);
        write_at(b + 40, 8'h03, 1);
        drain();

        b = cyc + 2;
        write_at(b, 8'h3C, 5);
        drain();

        // Write on the drain cycle is kept; the next one overflows
        b = cyc + 2;
        write_at(b, 8'hE1, 1);
        write_at(b + 20, 8'h96, 1);
        write_at(b + FRAME, 8'h4B, 1);
        write_at(b + FRAME + 10, 8'hFF, 2);
        drain();

        // Write exactly at the end of a frame with the buffer empty
        b = cyc + 2;
        write_at(b, 8'h80, 1);
        write_at(b + FRAME, 8'h7E, 1);
        drain();

        for (int i = 0; i < 60; i++) begin
            write_at(cyc + 1 + $urandom_range(1, FRAME + 40), 8'($urandom), $urandom_range(1, 4));
        end
        drain();

        // Asynchronous reset mid-frame with the buffer full
        b = cyc + 2;
        write_at(b, 8'hC5, 1);
        write_at(b + 20, 8'h5A, 1);
        while (cyc < b + 70) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_tx", int'(tx), 1);
        check("midreset_idle", int'(idle), 1);
        check("midreset_overflow", int'(overflow), 0);
        exp_q.delete();
        ovf_q.delete();
        last_start  = 0;
        last_end    = 0;
        chain_start = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);

        check("leftover_frames", exp_q.size(), 0);
        check("leftover_overflow", ovf_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
